// File: rtl/gelato_wb_pkg.sv
// gelato_wb_pkg: shared types and default widths for the write-back path.
// Contents:
//   DEF_NUM_SRC / DEF_CNT_W     default arbiter parameters
//   WARP_ID_W, REG_ADDR_W,
//   THREAD_NUM, DATA_W          payload field widths
//   SRC_COMPUTE/MEM/TENSOR      fixed source indices on the arbiter inputs
//   wb_req_t                    one write-back request (warp, rd, lane mask, lane data)
//   ptr_width()                 width of a source index, at least 1 bit
package gelato_wb_pkg;

  localparam int DEF_NUM_SRC = 3;
  localparam int WARP_ID_W   = 5;
  localparam int REG_ADDR_W  = 5;
  localparam int THREAD_NUM  = 32;
  localparam int DATA_W      = 32;
  localparam int DEF_CNT_W   = 32;

  localparam int SRC_COMPUTE = 0;
  localparam int SRC_MEM     = 1;
  localparam int SRC_TENSOR  = 2;

  typedef struct packed {
    logic [WARP_ID_W-1:0]                  warp_id;
    logic [REG_ADDR_W-1:0]                 rd;
    logic [THREAD_NUM-1:0]                 mask;
    logic [THREAD_NUM-1:0][DATA_W-1:0]     data;
  } wb_req_t;

  // A single source still needs a 1-bit index signal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gelato_rr_pick.sv
// gelato_rr_pick: combinational round-robin picker.
// Ports:
//   req       in   NUM_SRC  request vector
//   last_ptr  in   PTR_W    index of the most recent winner
//   grant     out  NUM_SRC  one-hot grant (all zero when no request)
//   idx       out  PTR_W    index of the granted request
//   any       out  1        at least one request is present
// Scanning starts at last_ptr+1 and wraps explicitly modulo NUM_SRC, so an
// index of NUM_SRC or above is never produced even if PTR_W could hold it.
module gelato_rr_pick
  import gelato_wb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;
  logic             found;

  assign any = |req;

  // Walk the sources once, in priority order after the last winner; the
  // first requesting one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = PTR_W'((int'(last_ptr) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/gelato_wb_arbiter.sv
// gelato_wb_arbiter: shares the register-file write-back port between the
// execution units (0 = compute, 1 = mem, 2 = tensor).
// Ports:
//   clk        in   1                 clock
//   rst        in   1                 synchronous active-high reset
//   rdy        in   1                 global enable; low freezes all state
//   req_valid  in   NUM_SRC           per-source request valid
//   req_ready  out  NUM_SRC           per-source accept (combinational)
//   req_data   in   NUM_SRC x wb_req_t per-source payload
//   wb_valid   out  1                 output entry valid
//   wb_ready   in   1                 register file takes the entry
//   wb_data    out  wb_req_t          registered output payload
//   wb_src     out  PTR_W             source index of the output entry
//   stall_cnt  out  CNT_W             saturating count of cycles with a waiter
// One request per cycle is picked round-robin and registered into a
// one-entry output stage; a draining entry is replaced in the same cycle,
// so back-to-back writes flow with no bubble.
module gelato_wb_arbiter
  import gelato_wb_pkg::*;
#(
  parameter  int NUM_SRC = DEF_NUM_SRC,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [NUM_SRC-1:0] req_valid,
  output logic [NUM_SRC-1:0] req_ready,
  input  wb_req_t            req_data [NUM_SRC],
  output logic               wb_valid,
  input  logic               wb_ready,
  output wb_req_t            wb_data,
  output logic [PTR_W-1:0]   wb_src,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   last_ptr;
  logic               any_req;
  logic               load_en;
  logic               xfer;
  logic               waiting;

  gelato_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .grant    (grant),
    .idx      (pick_idx),
    .any      (any_req)
  );

  // The output stage can take a new entry when it is empty or being drained
  // this cycle. Ready is derived only from valids and output state.
  assign load_en   = rdy && (!wb_valid || wb_ready);
  assign xfer      = load_en && any_req;
  assign req_ready = xfer ? grant : '0;

  // A cycle counts as a stall when more requests are present than were taken.
  assign waiting   = rdy && ($countones(req_valid) > (xfer ? 1 : 0));

  // Output register, round-robin pointer and stall counter. The pointer only
  // moves on an accepted transfer so a blocked winner keeps its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_src    <= '0;
      last_ptr  <= PTR_W'(NUM_SRC - 1);
      stall_cnt <= '0;
    end else if (rdy) begin
      if (xfer) begin
        wb_valid <= 1'b1;
        wb_data  <= req_data[pick_idx];
        wb_src   <= pick_idx;
        last_ptr <= pick_idx;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (waiting && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// tb_gelato_wb_arbiter: table-driven bench for the write-back arbiter.
// A second instance with a 3-bit stall counter sees the same stimulus so the
// saturation of the counter is observable within a short run.
module tb_gelato_wb_arbiter;
  import gelato_wb_pkg::*;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [NS-1:0] req_valid;
  logic          wb_ready;
  wb_req_t       req_data [NS];

  logic [NS-1:0] req_ready,   req_ready_s;
  logic          wb_valid,    wb_valid_s;
  wb_req_t       wb_data,     wb_data_s;
  logic [1:0]    wb_src,      wb_src_s;
  logic [31:0]   stall_cnt;
  logic [2:0]    stall_cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gelato_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .stall_cnt (stall_cnt)
  );

  gelato_wb_arbiter #(.CNT_W(3)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .req_valid (req_valid),
    .req_ready (req_ready_s),
    .req_data  (req_data),
    .wb_valid  (wb_valid_s),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data_s),
    .wb_src    (wb_src_s),
    .stall_cnt (stall_cnt_s)
  );

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [2:0] valid;
    logic       wbr;
    logic [7:0] tag0;
    logic [7:0] tag1;
    logic [7:0] tag2;
    logic [2:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_src;
    logic [7:0] exp_tag;
    int         exp_stall;
  } vec_t;

  vec_t vecs[$];

  // Payload derived from (source, tag); tag 0 on source 0 is all zeros,
  // which matches the reset value of the output register.
  function automatic wb_req_t build_req(input int src, input logic [7:0] tag);
    wb_req_t r;
    r.warp_id = WARP_ID_W'(src) ^ tag[4:0];
    r.rd      = tag[4:0];
    r.mask    = {4{tag}};
    for (int l = 0; l < THREAD_NUM; l++) r.data[l] = 32'(tag) * 32'(l + 1);
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic en, input logic [2:0] v,
                              input logic wr, input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input logic [2:0] er, input logic ev,
                              input logic [1:0] es, input logic [7:0] et, input int st);
    vec_t x;
    x.rst = r; x.rdy = en; x.valid = v; x.wbr = wr;
    x.tag0 = t0; x.tag1 = t1; x.tag2 = t2;
    x.exp_ready = er; x.exp_valid = ev; x.exp_src = es; x.exp_tag = et; x.exp_stall = st;
    return x;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    rdy         = v.rdy;
    req_valid   = v.valid;
    wb_ready    = v.wbr;
    req_data[0] = build_req(0, v.tag0);
    req_data[1] = build_req(1, v.tag1);
    req_data[2] = build_req(2, v.tag2);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input wb_req_t act, input wb_req_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got warp=%0h rd=%0h mask=%0h lane0=%0h expected warp=%0h rd=%0h mask=%0h lane0=%0h",
               name, act.warp_id, act.rd, act.mask, act.data[0],
               exp.warp_id, exp.rd, exp.mask, exp.data[0]);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [1:0] es,
                          input wb_req_t ed, input int st);
    int st_small;
    st_small = (st > 7) ? 7 : st;
    checkOutput({tag, " wb_valid"}, 64'(wb_valid), 64'(ev));
    checkOutput({tag, " wb_src"}, 64'(wb_src), 64'(es));
    checkData({tag, " wb_data"}, wb_data, ed);
    checkOutput({tag, " stall_cnt"}, 64'(stall_cnt), 64'(st));
    checkOutput({tag, " small wb_valid"}, 64'(wb_valid_s), 64'(ev));
    checkOutput({tag, " small wb_src"}, 64'(wb_src_s), 64'(es));
    checkData({tag, " small wb_data"}, wb_data_s, ed);
    checkOutput({tag, " small stall_cnt"}, 64'(stall_cnt_s), 64'(st_small));
  endtask

  initial begin
    bit granted;

    rst = 1'b1; rdy = 1'b1; req_valid = '0; wb_ready = 1'b0;
    for (int i = 0; i < NS; i++) req_data[i] = '0;

    // Reset, then a lone mem request with rd=7.
    vecs.push_back(mk(1,1,3'b000,0, 8'h00,8'h00,8'h00, 3'b000,0,0,8'h00,0));
    vecs.push_back(mk(0,1,3'b010,1, 8'h00,8'h07,8'h00, 3'b010,1,1,8'h07,0));
    // Reset again, then all three requesting: grants 0,1,2,0,1,2.
    vecs.push_back(mk(1,1,3'b000,1, 8'h00,8'h00,8'h00, 3'b000,0,0,8'h00,0));
    vecs.push_back(mk(0,1,3'b111,1, 8'h10,8'h21,8'h32, 3'b001,1,0,8'h10,1));
    vecs.push_back(mk(0,1,3'b111,1, 8'h11,8'h21,8'h32, 3'b010,1,1,8'h21,2));
    vecs.push_back(mk(0,1,3'b111,1, 8'h11,8'h22,8'h32, 3'b100,1,2,8'h32,3));
    vecs.push_back(mk(0,1,3'b111,1, 8'h11,8'h22,8'h33, 3'b001,1,0,8'h11,4));
    vecs.push_back(mk(0,1,3'b111,1, 8'h12,8'h22,8'h33, 3'b010,1,1,8'h22,5));
    vecs.push_back(mk(0,1,3'b111,1, 8'h12,8'h23,8'h33, 3'b100,1,2,8'h33,6));
    // Back-pressure for 4 cycles with tensor waiting, then it loads at once.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,1,3'b100,0, 8'h00,8'h00,8'h34, 3'b000,1,2,8'h33,7+k));
    vecs.push_back(mk(0,1,3'b100,1, 8'h00,8'h00,8'h34, 3'b100,1,2,8'h34,10));
    // Compute alone for 5 cycles: one write per cycle.
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,1,3'b001,1, 8'(8'h40+k),8'h00,8'h00, 3'b001,1,0,8'(8'h40+k),10));
    // Traffic frozen by rdy=0 for 3 cycles, then resuming.
    vecs.push_back(mk(0,1,3'b011,1, 8'h45,8'h50,8'h00, 3'b010,1,1,8'h50,11));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,3'b011,1, 8'h45,8'h51,8'h00, 3'b000,1,1,8'h50,11));
    vecs.push_back(mk(0,1,3'b011,1, 8'h45,8'h51,8'h00, 3'b001,1,0,8'h45,12));
    // Reset with a held entry and compute/tensor pending; compute wins first.
    vecs.push_back(mk(1,1,3'b101,0, 8'h46,8'h00,8'h60, 3'b000,0,0,8'h00,0));
    vecs.push_back(mk(0,1,3'b101,1, 8'h46,8'h00,8'h60, 3'b001,1,0,8'h46,1));
    vecs.push_back(mk(0,1,3'b100,1, 8'h00,8'h00,8'h60, 3'b100,1,2,8'h60,1));
    vecs.push_back(mk(0,1,3'b000,1, 8'h00,8'h00,8'h00, 3'b000,0,2,8'h60,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d small req_ready", i), 64'(req_ready_s), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      checkAll($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_src,
               build_req(int'(vecs[i].exp_src), vecs[i].exp_tag), vecs[i].exp_stall);
    end

    // Hand sequence: mem request from an idle output, with a bounded wait.
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1; wb_ready = 1'b1;
    req_valid = 3'b010;
    req_data[0] = '0; req_data[1] = build_req(1, 8'h70); req_data[2] = '0;
    granted = 1'b0;
    for (int c = 0; c < 4 && !granted; c++) begin
      #1;
      if (req_ready == 3'b010) granted = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++;
    if (!granted) begin
      failures++;
      $display("[TB] FAIL hand grant_wait: got req_ready=%0b expected 010 within 4 cycles", req_ready);
    end
    @(posedge clk);
    #1;
    checkAll("hand mem", 1'b1, 2'd1, build_req(1, 8'h70), 1);

    // Tensor write with an all-zero lane mask is forwarded like any write.
    @(negedge clk);
    req_valid = 3'b100;
    req_data[1] = '0; req_data[2] = build_req(2, 8'h00);
    #1;
    checkOutput("hand zero_mask req_ready", 64'(req_ready), 64'(3'b100));
    @(posedge clk);
    #1;
    checkAll("hand zero_mask", 1'b1, 2'd2, build_req(2, 8'h00), 1);

    // Idle cycle drains the entry.
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    checkAll("hand drain", 1'b0, 2'd2, build_req(2, 8'h00), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
